// File: rtl/stream_packer.sv
// stream_packer: packs RATIO narrow input beats into one wide output word.
// A beat with in_last_i closes the word early, leaving a partial word with a lane count.
module stream_packer #(
    parameter int IN_W  = 8,
    parameter int RATIO = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [IN_W-1:0]              in_data_i,
    input  logic                         in_last_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic [IN_W*RATIO-1:0]        out_data_o,
    output logic [$clog2(RATIO+1)-1:0]   out_count_o,
    output logic                         out_last_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int CNT_W = $clog2(RATIO + 1);
    localparam int IDX_W = $clog2(RATIO);

    if (IN_W < 1 || RATIO < 2) begin : g_bad_params
        $error("stream_packer: IN_W must be >= 1 and RATIO >= 2");
    end

    logic [OUT_W-1:0] r_acc;
    logic [IDX_W-1:0] r_idx;
    logic [OUT_W-1:0] r_data;
    logic [CNT_W-1:0] r_count;
    logic             r_last;
    logic             r_valid;
    logic [OUT_W-1:0] w_merged;
    logic             w_accept;
    logic             w_done;

    assign in_ready_o  = !r_valid || out_ready_i;
    assign out_valid_o = r_valid;
    assign out_data_o  = r_data;
    assign out_count_o = r_count;
    assign out_last_o  = r_last;
    assign w_accept    = in_valid_i && in_ready_o;
    assign w_done      = w_accept && (in_last_i || r_idx == IDX_W'(RATIO - 1));

    // Lanes above the current index are forced to zero so partial words are clean.
    for (genvar k = 0; k < RATIO; k++) begin : g_lane
        localparam logic [IDX_W-1:0] K = IDX_W'(k);
        assign w_merged[k*IN_W +: IN_W] = (K == r_idx) ? in_data_i :
                                          (K <  r_idx) ? r_acc[k*IN_W +: IN_W] : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_count <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_done) begin
            r_acc   <= '0;
            r_idx   <= '0;
            r_data  <= w_merged;
            r_count <= CNT_W'(r_idx) + CNT_W'(1);
            r_last  <= in_last_i;
            r_valid <= 1'b1;
        end else begin
            if (w_accept) begin
                r_acc <= w_merged;
                r_idx <= r_idx + IDX_W'(1);
            end
            if (out_ready_i) r_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stream_packer.sv
// tb_stream_packer: directed checks of stream_packer (IN_W=8, RATIO=4) plus a scoreboarded random phase.
module tb_stream_packer;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  in_data_i;
    logic        in_last_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] out_data_o;
    logic [2:0]  out_count_o;
    logic        out_last_o;
    logic        out_valid_o;
    logic        out_ready_i;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] d;
        int          c;
        logic        l;
    } word_t;
    word_t exp_q[$];

    stream_packer #(.IN_W(8), .RATIO(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_count_o (out_count_o),
        .out_last_o  (out_last_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = l;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] d, input int c, input logic l);
        chk({tag, ".valid"}, 32'(out_valid_o), 32'd1);
        chk({tag, ".data"},  out_data_o, d);
        chk({tag, ".count"}, 32'(out_count_o), 32'(c));
        chk({tag, ".last"},  32'(out_last_o), 32'(l));
    endtask

    initial begin
        logic [31:0] b_word;
        int          b_n;
        logic        ov, ol, rdy, iv, il, ordy;
        logic [31:0] od;
        logic [2:0]  oc;
        logic [7:0]  id;
        word_t       w;
        rst_ni      = 1'b0;
        in_data_i   = '0;
        in_last_i   = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        #3;
        chk("rst.valid", 32'(out_valid_o), 32'd0);
        chk("rst.data",  out_data_o, 32'd0);
        chk("rst.count", 32'(out_count_o), 32'd0);
        chk("rst.last",  32'(out_last_o), 32'd0);
        chk("rst.ready", 32'(in_ready_o), 32'd1);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        chk("full.no_early_valid", 32'(out_valid_o), 32'd0);
        beat(8'h44, 1'b0);
        chk_out("full", 32'h44332211, 4, 1'b0);
        @(posedge clk_i);
        #1;
        chk("full.consumed", 32'(out_valid_o), 32'd0);

        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b1);
        chk_out("early", 32'h0000BBAA, 2, 1'b1);
        @(posedge clk_i);
        #1;
        beat(8'h5C, 1'b1);
        chk_out("lane0", 32'h0000005C, 1, 1'b1);
        @(posedge clk_i);
        #1;

        beat(8'hA1, 1'b0);
        beat(8'hA2, 1'b0);
        beat(8'hA3, 1'b0);
        out_ready_i = 1'b0;
        beat(8'hA4, 1'b0);
        in_valid_i = 1'b1;
        in_data_i  = 8'h99;
        in_last_i  = 1'b1;
        #1;
        chk("stall.in_ready", 32'(in_ready_o), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i);
            #1;
            chk_out("stall.hold", 32'hA4A3A2A1, 4, 1'b0);
        end
        out_ready_i = 1'b1;
        in_data_i   = 8'hEE;
        #1;
        chk("release.in_ready", 32'(in_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        chk_out("nobubble", 32'h000000EE, 1, 1'b1);
        @(posedge clk_i);
        #1;
        chk("nobubble.consumed", 32'(out_valid_o), 32'd0);

        beat(8'h77, 1'b0);
        beat(8'h88, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst.valid", 32'(out_valid_o), 32'd0);
        chk("midrst.data",  out_data_o, 32'd0);
        chk("midrst.count", 32'(out_count_o), 32'd0);
        chk("midrst.last",  32'(out_last_o), 32'd0);
        chk("midrst.ready", 32'(in_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h03, 1'b0);
        beat(8'h04, 1'b0);
        chk_out("postrst", 32'h04030201, 4, 1'b0);
        @(posedge clk_i);
        #1;

        b_word = '0;
        b_n    = 0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            iv   = (cyc < 1180) && ($urandom_range(3) != 0);
            ordy = (cyc >= 1180) || ($urandom_range(2) != 0);
            id   = 8'($urandom);
            il   = ($urandom_range(4) == 0);
            in_valid_i  = iv;
            out_ready_i = ordy;
            in_data_i   = id;
            in_last_i   = il;
            #1;
            rdy = in_ready_o;
            ov  = out_valid_o;
            od  = out_data_o;
            oc  = out_count_o;
            ol  = out_last_o;
            chk("rand.in_ready", 32'(rdy), 32'(!ov || ordy));
            @(posedge clk_i);
            #1;
            if (ov && ordy) begin
                if (exp_q.size() == 0) begin
                    chk("rand.unexpected_word", 32'd1, 32'd0);
                end else begin
                    w = exp_q.pop_front();
                    chk("rand.data",  od, w.d);
                    chk("rand.count", 32'(oc), 32'(w.c));
                    chk("rand.last",  32'(ol), 32'(w.l));
                end
            end
            if (iv && rdy) begin
                b_word[b_n*8 +: 8] = id;
                b_n++;
                if (b_n == 4 || il) begin
                    exp_q.push_back('{b_word, b_n, il});
                    b_word = '0;
                    b_n    = 0;
                end
            end
        end
        chk("rand.drained", 32'(exp_q.size()), 32'd0);
        chk("rand.no_partial_out", 32'(out_valid_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
